// File: rtl/zone_alarm_ctrl.sv
// zone_alarm_ctrl: multi-zone intruder alarm controller.
// Synchronises and debounces N_ZONES sensor pins plus the key switch, then runs the
// arming FSM (DISARMED -> EXIT -> ARMED -> ENTRY/ALARM) with per-zone bypass and
// first-trip zone capture.
// Optional feature: define ALARM_AUTO_SILENCE_EN to time-limit the siren to SIREN_CYC
// cycles per trip while the FSM stays in ALARM.
module zone_alarm_ctrl #(
  parameter int N_ZONES   = 4,
  parameter int DEB_CYC   = 16,
  parameter int EXIT_CYC  = 1000,
  parameter int ENTRY_CYC = 1000,
  parameter int SIREN_CYC = 5000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_i,
  input  logic [N_ZONES-1:0] zone_i,
  input  logic [N_ZONES-1:0] bypass_i,
  output logic               ready_o,
  output logic               armed_o,
  output logic               siren_o,
  output logic [N_ZONES-1:0] zone_lat_o,
  output logic [2:0]         state_o
);

  // Key switch rides along with the zones as the top bit of one debounce vector
  localparam int NB      = N_ZONES + 1;
  localparam int DW      = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;
  localparam int MAX_EE  = (EXIT_CYC > ENTRY_CYC) ? EXIT_CYC : ENTRY_CYC;
  localparam int MAX_CYC = (MAX_EE > SIREN_CYC) ? MAX_EE : SIREN_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [N_ZONES-1:0] ZONE0_MASK = N_ZONES'(1);
  localparam logic [N_ZONES-1:0] HIGH_MASK  = ~ZONE0_MASK;

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  logic [NB-1:0]      w_pins;
  logic [NB-1:0]      r_sync1;
  logic [NB-1:0]      r_sync2;
  logic [NB-1:0]      r_deb;
  logic [DW-1:0]      r_debCnt [NB];

  logic [N_ZONES-1:0] w_debZone;
  logic               w_debKey;
  logic [N_ZONES-1:0] w_bypEff;
  logic [N_ZONES-1:0] w_active;
  logic               w_anyHigh;
  logic [N_ZONES-1:0] w_firstHigh;

  state_t             r_state;
  logic [TW-1:0]      r_timer;
  logic [N_ZONES-1:0] r_bypLat;
  logic [N_ZONES-1:0] r_zoneLat;
  logic               r_armed;
  logic               r_siren;

  assign w_pins    = {key_i, zone_i};
  assign w_debZone = r_deb[N_ZONES-1:0];
  assign w_debKey  = r_deb[N_ZONES];

  // While disarmed the live bypass switches decide readiness, so the user sees the
  // effect of a bypass before arming; once armed the latched copy is used.
  assign w_bypEff  = (r_state == S_DISARMED) ? bypass_i : r_bypLat;
  assign w_active  = w_debZone & ~w_bypEff;
  assign w_anyHigh = |(w_active & HIGH_MASK);

  assign ready_o    = ~|w_active;
  assign armed_o    = r_armed;
  assign siren_o    = r_siren;
  assign zone_lat_o = r_zoneLat;
  assign state_o    = r_state;

  // Two-flop synchroniser for every asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_pins;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debounce: accept a new level only after DEB_CYC consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb <= '0;
      for (int b = 0; b < NB; b++) r_debCnt[b] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (r_sync2[b] != r_deb[b]) begin
          if (r_debCnt[b] == DW'(DEB_CYC - 1)) begin
            r_deb[b]    <= r_sync2[b];
            r_debCnt[b] <= '0;
          end else begin
            r_debCnt[b] <= r_debCnt[b] + DW'(1);
          end
        end else begin
          r_debCnt[b] <= '0;
        end
      end
    end
  end

  // One-hot of the lowest-index active zone above zone 0 (instant-alarm zones)
  always_comb begin
    w_firstHigh = '0;
    for (int k = N_ZONES - 1; k >= 1; k--) begin
      if (w_active[k]) begin
        w_firstHigh    = '0;
        w_firstHigh[k] = 1'b1;
      end
    end
  end

`ifdef ALARM_AUTO_SILENCE_EN
  logic [TW-1:0]      r_sirenTmr;
  logic [N_ZONES-1:0] r_actPrev;
  logic               w_newTrip;

  // A freshly opened zone other than the captured one counts as a new trip
  assign w_newTrip = |(w_active & ~r_actPrev & ~r_zoneLat);

  // Siren on-time: preloaded in the states that can enter ALARM, counted down in ALARM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sirenTmr <= '0;
      r_actPrev  <= '0;
    end else begin
      r_actPrev <= w_active;
      if (r_state == S_ARMED || r_state == S_ENTRY) begin
        r_sirenTmr <= TW'(SIREN_CYC);
      end else if (r_state == S_ALARM) begin
        if (r_sirenTmr == '0 && w_newTrip) r_sirenTmr <= TW'(SIREN_CYC);
        else if (r_sirenTmr != '0)         r_sirenTmr <= r_sirenTmr - TW'(1);
      end else begin
        r_sirenTmr <= '0;
      end
    end
  end
`endif

  // Arming FSM with registered armed/siren outputs; disarm always wins, then k>0 trips, then zone 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_DISARMED;
      r_timer   <= '0;
      r_bypLat  <= '0;
      r_zoneLat <= '0;
      r_armed   <= 1'b0;
      r_siren   <= 1'b0;
    end else begin
      case (r_state)
        S_DISARMED: begin
          if (w_debKey && ready_o) begin
            r_state   <= S_EXIT;
            r_bypLat  <= bypass_i;
            r_timer   <= TW'(EXIT_CYC);
            r_zoneLat <= '0;
            r_armed   <= 1'b1;
          end
        end
        S_EXIT: begin
          if (!w_debKey) begin
            r_state <= S_DISARMED;
            r_timer <= '0;
            r_armed <= 1'b0;
          end else if (r_timer <= TW'(1)) begin
            r_state <= S_ARMED;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_ARMED: begin
          if (!w_debKey) begin
            r_state <= S_DISARMED;
            r_armed <= 1'b0;
          end else if (w_anyHigh) begin
            r_state   <= S_ALARM;
            r_zoneLat <= w_firstHigh;
            r_siren   <= 1'b1;
          end else if (w_active[0]) begin
            r_state   <= S_ENTRY;
            r_timer   <= TW'(ENTRY_CYC);
            r_zoneLat <= ZONE0_MASK;
          end
        end
        S_ENTRY: begin
          if (!w_debKey) begin
            r_state <= S_DISARMED;
            r_timer <= '0;
            r_armed <= 1'b0;
          end else if (w_anyHigh || r_timer <= TW'(1)) begin
            r_state <= S_ALARM;
            r_timer <= '0;
            r_siren <= 1'b1;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_ALARM: begin
          if (!w_debKey) begin
            r_state <= S_DISARMED;
            r_armed <= 1'b0;
            r_siren <= 1'b0;
          end else begin
`ifdef ALARM_AUTO_SILENCE_EN
            r_siren <= (r_sirenTmr > TW'(1)) || (r_sirenTmr == '0 && w_newTrip);
`else
            r_siren <= 1'b1;
`endif
          end
        end
        default: begin
          r_state <= S_DISARMED;
          r_armed <= 1'b0;
          r_siren <= 1'b0;
        end
      endcase
    end
  end

endmodule
